// File: rtl/ecc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_spi_pkg
// Purpose  : Shared types and constants for the ECC SPI front-end and its
//            register map: address width, receiver FSM states, register
//            base addresses and operand length.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_spi_pkg;

  // Register address width on the SPI link
  localparam int SPI_ADDR_W = 8;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  // Register map base addresses
  localparam logic [SPI_ADDR_W-1:0] REG_X      = 8'h10;
  localparam logic [SPI_ADDR_W-1:0] REG_Y      = 8'h30;
  localparam logic [SPI_ADDR_W-1:0] REG_K      = 8'h50;
  localparam logic [SPI_ADDR_W-1:0] REG_B      = 8'h70;
  localparam logic [SPI_ADDR_W-1:0] REG_RES_X  = 8'h90;
  localparam logic [SPI_ADDR_W-1:0] REG_RES_Y  = 8'hB0;
  localparam logic [SPI_ADDR_W-1:0] REG_STATUS = 8'hF0;
  localparam logic [SPI_ADDR_W-1:0] REG_START  = 8'hFF;

  // Bytes in one field operand (163-bit values rounded up to bytes)
  localparam int OPERAND_BYTES = 21;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchroniser for one asynchronous input, followed by
//            a history flop that produces single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // Fewer than two flops gives no metastability protection; clamp silently.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         hist_q;

  // Synchroniser chain plus one history flop for edge detection. The chain
  // clears to 0 so a line that is high at reset release shows up as a rise,
  // and a falling edge is only ever seen after a real high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], async_i};
      hist_q <= sync_q[N-1];
    end
  end

  assign sync_o = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~hist_q;
  assign fall_o = ~sync_q[N-1] & hist_q;

endmodule
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_rx
// Purpose  : Oversampling SPI slave (mode 0, MSB first). First byte of each
//            CS-low frame is a register address, every later byte is a write
//            to the (auto-incrementing) address. Each address in use is read
//            from the register map so MISO streams its contents in-frame.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_rx
  import ecc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = SPI_ADDR_W,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_err,
  output logic              busy
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // --------------------------------------------------------------------------
  // Input synchronisation
  // --------------------------------------------------------------------------
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_unused_sclk_sync;
  logic w_unused_cs_sync;
  logic w_mosi;

  spi_sync_edge #(.STAGES(N)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_clk),
    .sync_o  (w_unused_sclk_sync),
    .rise_o  (w_sclk_rise),
    .fall_o  (w_sclk_fall)
  );

  // CS is active low: its synchronised fall starts a frame, rise ends it.
  spi_sync_edge #(.STAGES(N)) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_cs_n),
    .sync_o  (w_unused_cs_sync),
    .rise_o  (w_cs_rise),
    .fall_o  (w_cs_fall)
  );

  logic [N-1:0] mosi_sync_q;

  // MOSI gets the same depth as SCLK so the bit is aligned with its edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[N-2:0], spi_mosi};
    end
  end

  assign w_mosi = mosi_sync_q[N-1];

  // --------------------------------------------------------------------------
  // Frame FSM and datapath
  // --------------------------------------------------------------------------
  spi_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_sr_q;
  logic [7:0]        tx_sr_q;
  logic [ADDR_W-1:0] a_reg_q;
  logic [ADDR_W-1:0] a_reg_d;
  logic              load_q;
  logic              end_pend_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              frame_start_q;
  logic              frame_end_q;
  logic              frame_err_q;
  logic              busy_q;

  logic [7:0]        w_rx_next;
  logic              w_byte_done;

  assign w_rx_next   = {rx_sr_q, w_mosi};
  assign w_byte_done = w_sclk_rise && (bit_cnt_q == 3'd7);

  // Address to use for the next data byte once the current write commits
  always_comb begin
    a_reg_d = a_reg_q;
    if (AUTO_INC != 0) begin
      a_reg_d = a_reg_q + ADDR_W'(1);
    end
  end

  // Frame sequencing, byte assembly, write/read pipeline and TX shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_sr_q       <= 7'd0;
      tx_sr_q       <= 8'd0;
      a_reg_q       <= '0;
      load_q        <= 1'b0;
      end_pend_q    <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'd0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // Pulses default low
      wr_valid_q    <= 1'b0;
      rd_req_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      load_q        <= 1'b0;
      end_pend_q    <= 1'b0;

      // frame_end deferred by one cycle behind a byte committed at CS rise
      if (end_pend_q) begin
        frame_end_q <= 1'b1;
      end

      // Write cycle: step the address and fetch the register for the next byte.
      // Skipped once the frame has closed so no stray read side effects occur.
      if (wr_valid_q && (state_q == DATA)) begin
        a_reg_q   <= a_reg_d;
        rd_req_q  <= 1'b1;
        rd_addr_q <= a_reg_d;
      end

      // Register map answers one cycle after rd_req
      if (rd_req_q && (state_q != IDLE)) begin
        load_q <= 1'b1;
      end

      // The reload lands before the 8th SCLK fall, which therefore must not
      // shift; bit_cnt_q == 0 in a frame identifies that fall.
      if (load_q && (state_q != IDLE)) begin
        tx_sr_q <= rd_data;
        if (state_q == ADDR) begin
          state_q <= DATA;
        end
      end else if (w_sclk_fall && (state_q != IDLE) && (bit_cnt_q != 3'd0)) begin
        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
      end

      case (state_q)
        IDLE: begin
          // SCLK activity with CS high never reaches the bit counter. A CS
          // rise seen here only follows reset release and closes no frame.
          if (w_cs_fall) begin
            state_q       <= ADDR;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
            bit_cnt_q     <= 3'd0;
            rx_sr_q       <= 7'd0;
            tx_sr_q       <= 8'd0;
          end
        end

        default: begin
          if (w_sclk_rise) begin
            rx_sr_q   <= w_rx_next[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end

          if (w_byte_done) begin
            if (state_q == ADDR) begin
              a_reg_q <= ADDR_W'(w_rx_next);
              if (!w_cs_rise) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= ADDR_W'(w_rx_next);
              end
            end else begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= a_reg_q;
              wr_data_q  <= w_rx_next;
            end
          end

          // A byte completing in the CS-rise cycle is still written; its
          // frame_end then trails wr_valid by one cycle.
          if (w_cs_rise) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            if (w_byte_done && (state_q == DATA)) begin
              end_pend_q <= 1'b1;
            end else begin
              frame_end_q <= 1'b1;
              frame_err_q <= (bit_cnt_q != 3'd0) && !w_byte_done;
            end
          end
        end
      endcase
    end
  end

  assign spi_miso    = tx_sr_q[7];
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_rx
// Purpose  : Directed self-checking bench for spi_frame_rx. Drives an SPI
//            master, models the register map (rd_data = addr ^ 0xFF) and
//            checks writes, reads, MISO bytes and frame pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_rx;

  logic clk = 1'b0;
  logic rst_n;
  logic spi_clk;
  logic spi_mosi;
  logic spi_cs_n;

  logic       spi_miso0, wr_valid0, rd_req0, frame_start0, frame_end0, frame_err0, busy0;
  logic [7:0] wr_addr0, wr_data0, rd_addr0;
  logic [7:0] rd_data0 = 8'h00;

  logic       spi_miso1, wr_valid1, rd_req1, frame_start1, frame_end1, frame_err1, busy1;
  logic [7:0] wr_addr1, wr_data1, rd_addr1;
  logic [7:0] rd_data1 = 8'h00;

  always #10 clk = ~clk;

  spi_frame_rx #(.SYNC_STAGES(2), .ADDR_W(8), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso0), .wr_valid(wr_valid0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .frame_start(frame_start0), .frame_end(frame_end0), .frame_err(frame_err0), .busy(busy0)
  );

  spi_frame_rx #(.SYNC_STAGES(2), .ADDR_W(8), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso1), .wr_valid(wr_valid1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .frame_start(frame_start1), .frame_end(frame_end1), .frame_err(frame_err1), .busy(busy1)
  );

  // Register map model: registered data one cycle after rd_req
  always @(posedge clk) begin
    if (rd_req0) rd_data0 <= rd_addr0 ^ 8'hFF;
    if (rd_req1) rd_data1 <= rd_addr1 ^ 8'hFF;
  end

  // Event monitor, sampled on the inactive edge
  int         cyc = 0;
  int         fs_cnt = 0, fe_cnt = 0, fer_cnt = 0, err_alone = 0;
  int         wr_cyc = 0, fe_cyc = 0;
  logic [7:0] wa0[$], wd0[$], ra0[$], wa1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_valid0) begin wa0.push_back(wr_addr0); wd0.push_back(wr_data0); wr_cyc = cyc; end
    if (wr_valid1) wa1.push_back(wr_addr1);
    if (rd_req0) ra0.push_back(rd_addr0);
    if (frame_start0) fs_cnt++;
    if (frame_end0) begin fe_cnt++; fe_cyc = cyc; end
    if (frame_err0) begin fer_cnt++; if (!frame_end0) err_alone++; end
  end

  int         n_checks = 0;
  int         n_errors = 0;
  real        half_ns  = 130.0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Shift the top n bits of b, sampling MISO on each SCLK rise
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #(half_ns);
      spi_clk = 1'b1;
      mi[i] = spi_miso0;
      #(half_ns);
      spi_clk = 1'b0;
    end
  endtask

  // One complete frame carrying tx_q; the MISO bytes land in rx_q
  task automatic run_frame();
    logic [7:0] mi;
    rx_q.delete();
    spi_cs_n = 1'b0;
    #(half_ns);
    foreach (tx_q[i]) begin
      spi_bits(tx_q[i], 8, mi);
      rx_q.push_back(mi);
    end
    #(half_ns);
    spi_cs_n = 1'b1;
    #(4.0 * half_ns);
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation did not complete, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         b_wr, b_rd, b_fs, b_fe, b_fer, b_alone, b_wr1, n, mism;
    logic [7:0] mi, addr, ea;

    rst_n = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    #103.3;
    check("reset_outputs", {spi_miso0, wr_valid0, wr_addr0, wr_data0, rd_req0, rd_addr0,
                            frame_start0, frame_end0, frame_err0, busy0}, 32'd0);
    rst_n = 1'b1;
    #200;
    check("no_frame_end_after_reset", fe_cnt, 0);
    check("idle_not_busy", busy0, 1'b0);

    // ---- 1: reset mid-frame, then a fresh single write
    spi_cs_n = 1'b0;
    #(half_ns);
    spi_bits(8'hA5, 4, mi);
    check("busy_mid_frame", busy0, 1'b1);
    rst_n = 1'b0;
    #20;
    check("reset_mid_frame_outputs", {spi_miso0, wr_valid0, wr_addr0, wr_data0, rd_req0, rd_addr0,
                                      frame_start0, frame_end0, frame_err0, busy0}, 32'd0);
    spi_cs_n = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;
    b_wr = wa0.size(); b_fs = fs_cnt; b_fe = fe_cnt; b_fer = fer_cnt;
    tx_q = '{8'h10, 8'h5A};
    run_frame();
    check("t1_wr_count", wa0.size() - b_wr, 1);
    if (wa0.size() > b_wr) begin
      check("t1_wr_addr", wa0[b_wr], 8'h10);
      check("t1_wr_data", wd0[b_wr], 8'h5A);
    end
    check("t1_frame_start", fs_cnt - b_fs, 1);
    check("t1_frame_end", fe_cnt - b_fe, 1);
    check("t1_frame_err", fer_cnt - b_fer, 0);

    // ---- 2: 21-byte operand burst at 0x10
    b_wr = wa0.size(); b_fe = fe_cnt; b_fer = fer_cnt;
    tx_q = '{8'h10};
    for (int i = 0; i < 21; i++) tx_q.push_back(8'(i));
    run_frame();
    check("t2_wr_count", wa0.size() - b_wr, 21);
    if (wa0.size() - b_wr == 21) begin
      for (int i = 0; i < 21; i++) begin
        check($sformatf("t2_addr_%0d", i), wa0[b_wr + i], 8'(8'h10 + i));
        check($sformatf("t2_data_%0d", i), wd0[b_wr + i], 8'(i));
        check($sformatf("t2_miso_%0d", i), rx_q[i + 1], 8'(8'h10 + i) ^ 8'hFF);
      end
    end
    check("t2_frame_end", fe_cnt - b_fe, 1);
    check("t2_frame_err", fer_cnt - b_fer, 0);

    // ---- 3: readback of 0x90..0x92 with dummy bytes
    b_rd = ra0.size();
    tx_q = '{8'h90, 8'h00, 8'h00, 8'h00};
    run_frame();
    check("t3_miso_addr_byte", rx_q[0], 8'h00);
    check("t3_miso_0", rx_q[1], 8'h6F);
    check("t3_miso_1", rx_q[2], 8'h6E);
    check("t3_miso_2", rx_q[3], 8'h6D);
    check("t3_rd_count", ra0.size() - b_rd, 4);
    if (ra0.size() - b_rd == 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("t3_rd_addr_%0d", i), ra0[b_rd + i], 8'(8'h90 + i));
    end

    // ---- 4: SCLK glitches with CS high, then wrap at 0xFF
    b_wr = wa0.size(); b_fs = fs_cnt; b_wr1 = wa1.size();
    for (int i = 0; i < 3; i++) begin
      spi_clk = 1'b1; #(half_ns); spi_clk = 1'b0; #(half_ns);
    end
    check("t4_glitch_no_write", wa0.size() - b_wr, 0);
    check("t4_glitch_no_start", fs_cnt - b_fs, 0);
    tx_q = '{8'hFF, 8'hA1, 8'hA2};
    run_frame();
    check("t4_wr_count", wa0.size() - b_wr, 2);
    check("t4_wr_count_noinc", wa1.size() - b_wr1, 2);
    if (wa0.size() - b_wr == 2) begin
      check("t4_addr_0", wa0[b_wr], 8'hFF);
      check("t4_addr_1_wrap", wa0[b_wr + 1], 8'h00);
      check("t4_data_1", wd0[b_wr + 1], 8'hA2);
    end
    if (wa1.size() - b_wr1 == 2) begin
      check("t4_noinc_addr_0", wa1[b_wr1], 8'hFF);
      check("t4_noinc_addr_1", wa1[b_wr1 + 1], 8'hFF);
    end

    // ---- 5: abort after 5 bits of the second data byte
    b_wr = wa0.size(); b_fe = fe_cnt; b_fer = fer_cnt; b_alone = err_alone;
    spi_cs_n = 1'b0;
    #(half_ns);
    spi_bits(8'h30, 8, mi);
    spi_bits(8'hC3, 8, mi);
    spi_bits(8'h77, 5, mi);
    #(half_ns);
    spi_cs_n = 1'b1;
    #(4.0 * half_ns);
    check("t5_wr_count", wa0.size() - b_wr, 1);
    if (wa0.size() > b_wr) begin
      check("t5_wr_addr", wa0[b_wr], 8'h30);
      check("t5_wr_data", wd0[b_wr], 8'hC3);
    end
    check("t5_frame_end", fe_cnt - b_fe, 1);
    check("t5_frame_err", fer_cnt - b_fer, 1);
    check("t5_err_without_end", err_alone - b_alone, 0);

    // ---- CS rise on the same instant as the 8th SCLK rise
    b_wr = wa0.size(); b_fe = fe_cnt; b_fer = fer_cnt;
    spi_cs_n = 1'b0;
    #(half_ns);
    spi_bits(8'h50, 8, mi);
    spi_bits(8'h3C, 7, mi);
    spi_mosi = 1'b0;
    #(half_ns);
    spi_clk = 1'b1;
    spi_cs_n = 1'b1;
    #(half_ns);
    spi_clk = 1'b0;
    #(4.0 * half_ns);
    check("ts_wr_count", wa0.size() - b_wr, 1);
    if (wa0.size() > b_wr) begin
      check("ts_wr_addr", wa0[b_wr], 8'h50);
      check("ts_wr_data", wd0[b_wr], 8'h3C);
    end
    check("ts_frame_end", fe_cnt - b_fe, 1);
    check("ts_frame_err", fer_cnt - b_fer, 0);
    check("ts_end_after_write", fe_cyc - wr_cyc, 1);

    // ---- 6: 4 MHz and 1 MHz frames with random phase against clk
    for (int f = 0; f < 24; f++) begin
      half_ns = (f % 2 == 1) ? 500.0 : 125.0;
      #($urandom_range(1, 4999) / 1000.0);
      addr = 8'($urandom);
      n = $urandom_range(1, 3);
      tx_q = '{addr};
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      b_wr = wa0.size();
      run_frame();
      check($sformatf("t6_frame%0d_count", f), wa0.size() - b_wr, n);
      mism = 0;
      if (wa0.size() - b_wr == n) begin
        for (int i = 0; i < n; i++) begin
          ea = addr + 8'(i);
          if (wa0[b_wr + i] !== ea) mism++;
          if (wd0[b_wr + i] !== tx_q[i + 1]) mism++;
          if (rx_q[i + 1] !== (ea ^ 8'hFF)) mism++;
        end
      end
      check($sformatf("t6_frame%0d_content", f), mism, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
